// File: rtl/unidade_controle.sv
// unidade_controle: fetch/decode/execute sequencer driving the ULA and owning a 4x8 register file.
// Optional feature: define UC_BRANCH_ZERO_EN to turn op 1110 into BEQZ (branch when reg[ra]==0).
module unidade_controle #(
  parameter int PC_WIDTH    = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic                instr_valid,
  input  logic [15:0]         instr_data,
  output logic [7:0]          a,
  output logic [7:0]          b,
  output logic [3:0]          opcode,
  output logic [3:0]          endereco,
  output logic                enable,
  input  logic [7:0]          saidaULA,
  output logic                busy,
  output logic                halted,
  input  logic [1:0]          dbg_sel,
  output logic [7:0]          dbg_data,
  output logic [2:0]          dbg_state
);

  // Handshake: an instruction is accepted on a rising edge where instr_req and
  // instr_valid are both high; instr_valid is ignored whenever instr_req is low.
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT} state_t;

  localparam logic [7:0] WAIT_INIT = 8'(ALU_LATENCY - 2);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic [7:0]          regs [4];
  logic [7:0]          wait_cnt;

  logic [3:0]          ir_op;
  logic [1:0]          ir_rd, ir_ra, ir_rb;
  logic [7:0]          ir_imm;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] jmp_target;

  assign ir_op      = ir[15:12];
  assign ir_rd      = ir[11:10];
  assign ir_ra      = ir[9:8];
  assign ir_rb      = ir[7:6];
  assign ir_imm     = ir[7:0];
  assign pc_next    = pc + PC_WIDTH'(1);
  assign instr_addr = pc;
  assign dbg_data   = regs[dbg_sel];
  assign dbg_state  = state;

`ifdef UC_BRANCH_ZERO_EN
  assign jmp_target = (regs[ir_ra] == 8'd0) ? PC_WIDTH'(ir_imm) : pc_next;
`else
  assign jmp_target = PC_WIDTH'(ir_imm);
`endif

  // Outputs are registered, so each transition also sets the outputs of the state it enters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      wait_cnt  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      instr_req <= 1'b0;
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      endereco  <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            instr_req <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (instr_valid) begin
            ir        <= instr_data;
            instr_req <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (ir_op <= 4'hC) begin
            // Operands are sampled here, so rd may alias ra/rb safely.
            a        <= regs[ir_ra];
            b        <= regs[ir_rb];
            opcode   <= ir_op;
            endereco <= ir[3:0];
            enable   <= 1'b1;
            state    <= EXEC;
          end else if (ir_op == 4'hD) begin
            regs[ir_rd] <= ir_imm;
            pc          <= pc_next;
            instr_req   <= 1'b1;
            state       <= FETCH;
          end else if (ir_op == 4'hE) begin
            pc        <= jmp_target;
            instr_req <= 1'b1;
            state     <= FETCH;
          end else begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= HALT;
          end
        end
        EXEC: begin
          enable   <= 1'b0;
          wait_cnt <= WAIT_INIT;
          if (ALU_LATENCY == 1) state <= WB;
          else                  state <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 8'd0) state <= WB;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
        WB: begin
          if (ir_op != 4'hC) regs[ir_rd] <= saidaULA;
          pc        <= pc_next;
          instr_req <= 1'b1;
          state     <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
